// File: rtl/uart_ram_pkg.sv
// Shared types and helpers for the UART RAM-backed FIFO.
package uart_ram_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 15;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2
  } out_state_e;

  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'(1) << aw;
  endfunction

endpackage

// File: rtl/uart_ram_fifo_mem.sv
// Simple dual-port RAM, one write port, one read port with 1-cycle registered read; array not reset.
module uart_ram_fifo_mem
  import uart_ram_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_ram_fifo.sv
// Parametrised FWFT FIFO on an inferred SDP RAM with valid/ready on both sides.
// Optional frame commit/drop is enabled with `define UART_RAM_FIFO_FRAME_EN.
module uart_ram_fifo
  import uart_ram_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned AF_LVL = depth_of(ADDR_W) - 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              clr,
`ifdef UART_RAM_FIFO_FRAME_EN
  input  logic              wr_commit,
  input  logic              wr_drop,
`endif
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W:0]   level,
  output logic              almost_full,
  output logic              overflow
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);
  localparam int unsigned LW    = ADDR_W + 1;

  out_state_e        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d, pend_q, pend_d;
  logic [DATA_W-1:0] m_data_q, m_data_d, skid_q, skid_d;
  logic              skid_v_q, skid_v_d, infl_q, infl_d;
  logic              s_ready_q, s_ready_d, af_q, af_d, ovf_q, ovf_d, mv_d;
`ifdef UART_RAM_FIFO_FRAME_EN
  logic [ADDR_W-1:0] cmt_ptr_q, cmt_ptr_d;
`endif

  logic              wr, pop, issue, mv_q;
  logic [1:0]        stage_cnt;
  logic [LW-1:0]     avail;
  logic [DATA_W-1:0] ram_rdata;

  // Words in the output stage plus the read in flight; a new read is issued only if it will fit.
  assign mv_q      = (state_q == ST_VALID);
  assign wr        = s_valid & s_ready_q;
  assign pop       = mv_q & m_ready;
  assign stage_cnt = 2'(mv_q) + 2'(skid_v_q) + 2'(infl_q);
  assign avail     = level_q - LW'(stage_cnt);
  assign issue     = (avail != '0) && ((stage_cnt - 2'(pop)) < 2'd2);

  uart_ram_fifo_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
    .clk_i   (sys_clk),
    .we_i    (wr),
    .waddr_i (wr_ptr_q),
    .wdata_i (s_data),
    .re_i    (issue),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    pend_d   = pend_q;
    m_data_d = m_data_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    infl_d   = issue;
    mv_d     = mv_q;
    ovf_d    = ovf_q | (s_valid & ~s_ready_q);
`ifdef UART_RAM_FIFO_FRAME_EN
    cmt_ptr_d = cmt_ptr_q;
`endif

    if (issue) rd_ptr_d = rd_ptr_q + ADDR_W'(1);

    // Output stage: head register refills from skid first, then from the RAM read port.
    if (pop) begin
      if (skid_v_q) begin
        m_data_d = skid_q;
        skid_v_d = infl_q;
        if (infl_q) skid_d = ram_rdata;
      end else if (infl_q) begin
        m_data_d = ram_rdata;
      end else begin
        mv_d = 1'b0;
      end
    end else if (infl_q) begin
      if (mv_q) begin
        skid_d   = ram_rdata;
        skid_v_d = 1'b1;
      end else begin
        m_data_d = ram_rdata;
        mv_d     = 1'b1;
      end
    end

    if (wr) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
`ifdef UART_RAM_FIFO_FRAME_EN
    if (wr_drop) begin
      wr_ptr_d = cmt_ptr_q;
      pend_d   = '0;
    end else if (wr_commit) begin
      level_d   = level_q + pend_q + LW'(wr);
      pend_d    = '0;
      cmt_ptr_d = wr_ptr_d;
    end else begin
      pend_d = pend_q + LW'(wr);
    end
`else
    level_d = level_q + LW'(wr);
`endif
    level_d = level_d - LW'(pop);

    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      pend_d   = '0;
      skid_v_d = 1'b0;
      infl_d   = 1'b0;
      mv_d     = 1'b0;
      ovf_d    = 1'b0;
`ifdef UART_RAM_FIFO_FRAME_EN
      cmt_ptr_d = '0;
`endif
    end

    s_ready_d = (32'(level_d) + 32'(pend_d)) < DEPTH;
    af_d      = 32'(level_d) >= AF_LVL;
    state_d   = mv_d ? ST_VALID : (infl_d ? ST_FETCH : ST_EMPTY);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_EMPTY;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      pend_q    <= '0;
      m_data_q  <= '0;
      skid_q    <= '0;
      skid_v_q  <= 1'b0;
      infl_q    <= 1'b0;
      s_ready_q <= 1'b0;
      af_q      <= 1'b0;
      ovf_q     <= 1'b0;
`ifdef UART_RAM_FIFO_FRAME_EN
      cmt_ptr_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      pend_q    <= pend_d;
      m_data_q  <= m_data_d;
      skid_q    <= skid_d;
      skid_v_q  <= skid_v_d;
      infl_q    <= infl_d;
      s_ready_q <= s_ready_d;
      af_q      <= af_d;
      ovf_q     <= ovf_d;
`ifdef UART_RAM_FIFO_FRAME_EN
      cmt_ptr_q <= cmt_ptr_d;
`endif
    end
  end

  assign s_ready     = s_ready_q;
  assign m_data      = m_data_q;
  assign m_valid     = mv_q;
  assign level       = level_q;
  assign almost_full = af_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_uart_ram_fifo.sv
// Scoreboard bench for uart_ram_fifo with ADDR_W=4, DATA_W=8, AF_LVL=12.
module tb_uart_ram_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned AFL   = 12;
  localparam int unsigned DEPTH = 16;

  logic          sys_clk   = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          clr       = 1'b0;
  logic [DW-1:0] s_data    = '0;
  logic          s_valid   = 1'b0;
  logic          m_ready   = 1'b0;
  logic          s_ready, m_valid, almost_full, overflow;
  logic [DW-1:0] m_data;
  logic [AW:0]   level;
`ifdef UART_RAM_FIFO_FRAME_EN
  logic          wr_commit = 1'b0;
  logic          wr_drop   = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_wr = 0;
  int n_pop = 0;
  int first_pop_cyc = -1;
  int last_pop_cyc = 0;
  bit ovf_m = 1'b0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] pend_q[$];

  uart_ram_fifo #(.DATA_W(DW), .ADDR_W(AW), .AF_LVL(AFL)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .clr         (clr),
`ifdef UART_RAM_FIFO_FRAME_EN
    .wr_commit   (wr_commit),
    .wr_drop     (wr_drop),
`endif
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .level       (level),
    .almost_full (almost_full),
    .overflow    (overflow)
  );

  always #5 sys_clk = ~sys_clk;

  // Observe handshakes just before the edge, update the model, advance one cycle, check.
  task automatic tick();
    bit wr, pp, stall_now;
    logic [DW-1:0] held, e;
    wr = s_valid && s_ready;
    pp = m_valid && m_ready;
    if (pp && !clr) begin
      n_pop++;
      last_pop_cyc = cyc;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected: got %02h, scoreboard empty", m_data);
      end else begin
        e = exp_q.pop_front();
        if (m_data !== e) begin
          fails++;
          $display("FAIL pop_data: got %02h, expected %02h", m_data, e);
        end
      end
    end
    ovf_m = clr ? 1'b0 : (ovf_m | (s_valid && !s_ready));
    if (clr) begin
      exp_q.delete();
      pend_q.delete();
    end else begin
      if (wr) n_wr++;
`ifdef UART_RAM_FIFO_FRAME_EN
      if (wr_drop) pend_q.delete();
      else begin
        if (wr) pend_q.push_back(s_data);
        if (wr_commit) while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
      end
`else
      if (wr) exp_q.push_back(s_data);
`endif
    end
    stall_now = m_valid && !m_ready && !clr;
    held = m_data;
    @(posedge sys_clk);
    #1;
    cyc++;
    if (stall_now) begin
      tests++;
      if (m_valid !== 1'b1 || m_data !== held) begin
        fails++;
        $display("FAIL stall_hold: got valid=%b data=%02h, expected valid=1 data=%02h", m_valid, m_data, held);
      end
    end
    tests++;
    if (level !== (AW+1)'(exp_q.size())) begin
      fails++;
      $display("FAIL level: got %0d, expected %0d", level, exp_q.size());
    end
    tests++;
    if (s_ready !== ((exp_q.size() + pend_q.size()) < DEPTH)) begin
      fails++;
      $display("FAIL s_ready: got %b, expected %b", s_ready, (exp_q.size() + pend_q.size()) < DEPTH);
    end
    tests++;
    if (overflow !== ovf_m) begin
      fails++;
      $display("FAIL overflow: got %b, expected %b", overflow, ovf_m);
    end
  endtask

  task automatic drain();
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) tick();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d words left, expected 0", exp_q.size());
    end
    m_ready = 1'b0;
    tick();
    tests++;
    if (m_valid !== 1'b0 || level !== '0) begin
      fails++;
      $display("FAIL drained: got valid=%b level=%0d, expected 0/0", m_valid, level);
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    #12;
    tests++;
    if ({s_ready, m_valid, almost_full, overflow} !== 4'b0000 || m_data !== '0 || level !== '0) begin
      fails++;
      $display("FAIL reset_vals: got rdy=%b mv=%b af=%b ovf=%b data=%02h lvl=%0d, expected all 0",
               s_ready, m_valid, almost_full, overflow, m_data, level);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    tests++;
    if (s_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b, expected 1", s_ready);
    end
  endtask

  task automatic test_latency();
    s_data  = 8'hA5;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tests++;
    if (m_valid !== 1'b0) begin
      fails++;
      $display("FAIL lat_edge0: got m_valid=%b, expected 0", m_valid);
    end
    tick();
    tests++;
    if (m_valid !== 1'b0) begin
      fails++;
      $display("FAIL lat_edge1: got m_valid=%b, expected 0", m_valid);
    end
    tick();
    tests++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
      fails++;
      $display("FAIL lat_edge2: got valid=%b data=%02h, expected 1/a5", m_valid, m_data);
    end
    drain();
  endtask

  task automatic test_full();
    int start;
    start = n_wr;
    m_ready = 1'b0;
    for (int i = 0; i < 40 && (n_wr - start) < 16; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'h30 + (n_wr - start));
      tick();
      if (level == 5'd11) begin
        tests++;
        if (almost_full !== 1'b0) begin
          fails++;
          $display("FAIL af_below: got %b at level 11, expected 0", almost_full);
        end
      end
      if (level == 5'd12) begin
        tests++;
        if (almost_full !== 1'b1) begin
          fails++;
          $display("FAIL af_at: got %b at level 12, expected 1", almost_full);
        end
      end
    end
    tests++;
    if (level !== 5'd16 || s_ready !== 1'b0 || almost_full !== 1'b1) begin
      fails++;
      $display("FAIL full: got lvl=%0d rdy=%b af=%b, expected 16/0/1", level, s_ready, almost_full);
    end
    s_data = 8'hEE;
    tick();
    tests++;
    if (overflow !== 1'b1 || level !== 5'd16) begin
      fails++;
      $display("FAIL overflow_17th: got ovf=%b lvl=%0d, expected 1/16", overflow, level);
    end
    drain();
    tests++;
    if (almost_full !== 1'b0) begin
      fails++;
      $display("FAIL af_empty: got %b, expected 0", almost_full);
    end
  endtask

  task automatic test_back_to_back();
    int start, ticks, p0;
    start = n_wr;
    p0 = n_pop;
    ticks = 0;
    first_pop_cyc = -1;
    s_valid = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 300 && (n_wr - start) < 100; i++) begin
      s_data = 8'($urandom);
      tick();
      ticks++;
    end
    drain();
    tests++;
    if (ticks != 100) begin
      fails++;
      $display("FAIL stream_writes: got %0d cycles for 100 words, expected 100", ticks);
    end
    tests++;
    if ((n_pop - p0) != 100 || (last_pop_cyc - first_pop_cyc) != 99) begin
      fails++;
      $display("FAIL stream_gaps: got %0d pops over %0d cycles, expected 100 over 99",
               n_pop - p0, last_pop_cyc - first_pop_cyc);
    end
  endtask

  task automatic test_random_stall();
    for (int i = 0; i < 150; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 8'($urandom);
      m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    drain();
  endtask

  task automatic test_clr();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'h60 + i);
      tick();
    end
    tests++;
    if (level !== 5'd5) begin
      fails++;
      $display("FAIL clr_pre: got level %0d, expected 5", level);
    end
    s_data = 8'h77;
    clr    = 1'b1;
    tick();
    clr     = 1'b0;
    s_valid = 1'b0;
    tests++;
    if (level !== '0 || m_valid !== 1'b0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL clr_post: got lvl=%0d mv=%b ovf=%b, expected 0/0/0", level, m_valid, overflow);
    end
    tick();
    tick();
    tests++;
    if (m_valid !== 1'b0) begin
      fails++;
      $display("FAIL clr_write_lost: got m_valid=%b, expected 0", m_valid);
    end
  endtask

`ifdef UART_RAM_FIFO_FRAME_EN
  task automatic test_frame();
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'h90 + i);
      tick();
    end
    s_valid = 1'b0;
    wr_drop = 1'b1;
    tick();
    wr_drop = 1'b0;
    tick();
    tick();
    tests++;
    if (level !== '0 || m_valid !== 1'b0) begin
      fails++;
      $display("FAIL frame_drop: got lvl=%0d mv=%b, expected 0/0", level, m_valid);
    end
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'hC0 + i);
      tick();
    end
    s_data    = 8'hC2;
    wr_commit = 1'b1;
    tick();
    wr_commit = 1'b0;
    s_valid   = 1'b0;
    tests++;
    if (level !== 5'd3) begin
      fails++;
      $display("FAIL frame_commit: got level %0d, expected 3", level);
    end
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_full();
    test_back_to_back();
    test_random_stall();
    test_clr();
`ifdef UART_RAM_FIFO_FRAME_EN
    test_frame();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
